// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the synchronous FIFO and its storage.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    // Bits needed to index n values, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read (1 cycle).
// No flow control of its own; the controller only issues legal accesses.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W     = clog2_min1(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Array has no reset so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, any depth >= 2; read data registered, 1 cycle after rd_en.
// Writes refused when full, reads refused when empty; no bypass in either case.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AFULL_LVL  = FIFO_DEPTH - 2,
    parameter int AEMPTY_LVL = 2,
    localparam int CNT_W     = clog2_min1(FIFO_DEPTH + 1),
    localparam int PTR_W     = clog2_min1(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_val,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_LVL);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             wr_acc;
    logic             rd_acc;

    // Status decodes come only from the count register.
    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign wr_ready     = !full;
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    assign wr_acc = wr_en && !full  && !flush && !reset;
    assign rd_acc = rd_en && !empty && !flush && !reset;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rd_val    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                tail <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
            end
            if (rd_acc) begin
                head <= (head == PTR_LAST) ? '0 : head + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            rd_val <= rd_acc;
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // head != tail whenever both ports fire, so no read-during-write case.
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (tail),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (head),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo at depth 5: directed scenarios plus a random run
// against a queue-based reference model.
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_val;
    logic [2:0]    count;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_val  = 1'b0;
    logic          m_ovf     = 1'b0;
    logic          m_unf     = 1'b0;

    param_sync_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AFULL_LVL  (4),
        .AEMPTY_LVL (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_val       (rd_val),
        .count        (count),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic f, input logic rs);
        bit full_now;
        bit empty_now;
        wr_en = w; wr_data = d; rd_en = r; flush = f; reset = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_rd_data = '0; m_rd_val = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (f) begin
            mq.delete();
            m_rd_val = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            full_now  = (mq.size() == DEPTH);
            empty_now = (mq.size() == 0);
            if (w && full_now)  m_ovf = 1'b1;
            if (r && empty_now) m_unf = 1'b1;
            m_rd_val = r && !empty_now;
            if (r && !empty_now) m_rd_data = mq.pop_front();
            if (w && !full_now)  mq.push_back(d);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        chk_cnt++;
        if ({count, empty, wr_ready, almost_empty, almost_full} !== {3'd0, 4'b1110})
            $display("FAIL reset_flags got cnt=%0d e=%b wr=%b ae=%b af=%b want 0 1 1 1 0",
                     count, empty, wr_ready, almost_empty, almost_full);
        else pass_cnt++;
        chk_cnt++;
        if ({rd_val, overflow, underflow, rd_data} !== {3'b000, 8'h00})
            $display("FAIL reset_outs got val=%b ovf=%b unf=%b data=%h want 0 0 0 00",
                     rd_val, overflow, underflow, rd_data);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (wr_ready !== 1'b0 || count !== 3'd5)
            $display("FAIL fill_full got wr_ready=%b cnt=%0d want 0 5", wr_ready, count);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk_cnt++;
            if (rd_val !== 1'b1 || rd_data !== 8'h11 + 8'(i))
                $display("FAIL drain_%0d got val=%b data=%h want 1 %h", i, rd_val, rd_data, 8'h11 + 8'(i));
            else pass_cnt++;
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (empty !== 1'b1 || rd_val !== 1'b0 || rd_data !== 8'h15)
            $display("FAIL drain_end got empty=%b val=%b data=%h want 1 0 15", empty, rd_val, rd_data);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if ({rd_val, rd_data, overflow, count} !== {1'b1, 8'hA1, 1'b1, 3'd4})
            $display("FAIL ovf_rw got val=%b data=%h ovf=%b cnt=%0d want 1 a1 1 4",
                     rd_val, rd_data, overflow, count);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk_cnt++;
            if (rd_data !== 8'hA2 + 8'(i) || overflow !== 1'b1)
                $display("FAIL ovf_drain_%0d got data=%h ovf=%b want %h 1", i, rd_data, overflow, 8'hA2 + 8'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if ({rd_val, underflow, count} !== {1'b0, 1'b1, 3'd1})
            $display("FAIL unf_rw got val=%b unf=%b cnt=%0d want 0 1 1", rd_val, underflow, count);
        else pass_cnt++;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if ({rd_val, rd_data, underflow} !== {1'b1, 8'h3C, 1'b1})
            $display("FAIL unf_read got val=%b data=%h unf=%b want 1 3c 1", rd_val, rd_data, underflow);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(i + 3), 1'b1, 1'b0, 1'b0);
            if (count !== 3'd3 || rd_val !== 1'b1 || rd_data !== 8'(i)) begin
                if (errs == 0)
                    $display("FAIL stream_%0d got cnt=%0d val=%b data=%h want 3 1 %h",
                             i, count, rd_val, rd_data, 8'(i));
                errs++;
            end
        end
        chk_cnt++;
        if (errs != 0) $display("FAIL stream_total got %0d bad cycles want 0", errs);
        else pass_cnt++;
    endtask

    task automatic test_levels();
        int k = 0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(i < 5, 8'(i), i >= 5, 1'b0, 1'b0);
            k = (i < 5) ? i + 1 : 9 - i;
            chk_cnt++;
            if (count !== 3'(k) || almost_empty !== (k <= 1) || almost_full !== (k >= 4))
                $display("FAIL level_%0d got cnt=%0d ae=%b af=%b want %0d %b %b",
                         i, count, almost_empty, almost_full, k, k <= 1, k >= 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush_reset();
        for (int pass = 0; pass < 2; pass++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 6; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk_cnt++;
            if (count !== 3'd4 || overflow !== 1'b1 || rd_data !== 8'hC0)
                $display("FAIL clr_pre_%0d got cnt=%0d ovf=%b data=%h want 4 1 c0", pass, count, overflow, rd_data);
            else pass_cnt++;
            cycle(1'b1, 8'h99, 1'b1, pass == 0, pass == 1);
            chk_cnt++;
            if ({count, empty, overflow, rd_val} !== {3'd0, 1'b1, 1'b0, 1'b0} ||
                rd_data !== ((pass == 0) ? 8'hC0 : 8'h00))
                $display("FAIL clr_%0d got cnt=%0d e=%b ovf=%b val=%b data=%h want 0 1 0 0 %h",
                         pass, count, empty, overflow, rd_val, rd_data, (pass == 0) ? 8'hC0 : 8'h00);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic w, r, f, rs;
        for (int i = 0; i < 600; i++) begin
            w  = ($urandom_range(99) < ((i % 200) < 100 ? 75 : 30));
            r  = ($urandom_range(99) < ((i % 200) < 100 ? 30 : 75));
            f  = ($urandom_range(59) == 0);
            rs = ($urandom_range(149) == 0);
            cycle(w, 8'($urandom), r, f, rs);
            chk_cnt++;
            if (count !== 3'(mq.size()))
                $display("FAIL rnd_cnt_%0d got %0d want %0d", i, count, mq.size());
            else pass_cnt++;
            chk_cnt++;
            if ({empty, wr_ready, almost_full, almost_empty, overflow, underflow, rd_val} !==
                {mq.size() == 0, mq.size() < DEPTH, mq.size() >= 4, mq.size() <= 1, m_ovf, m_unf, m_rd_val})
                $display("FAIL rnd_flags_%0d got %b want %b", i,
                         {empty, wr_ready, almost_full, almost_empty, overflow, underflow, rd_val},
                         {mq.size() == 0, mq.size() < DEPTH, mq.size() >= 4, mq.size() <= 1, m_ovf, m_unf, m_rd_val});
            else pass_cnt++;
            chk_cnt++;
            if (rd_data !== m_rd_data)
                $display("FAIL rnd_data_%0d got %h want %h", i, rd_data, m_rd_data);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_levels();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
